// File: rtl/strontium_dmem_pkg.sv
// Shared types and constants for the DMEM port arbiter.
package strontium_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic master;
  } rd_tag_t;

  localparam int ADDR_W_DFLT = 32;
  // Address bit selecting the MMIO window inside DMEM; the arbiter passes it through untouched.
  localparam int MMIO_BIT    = ADDR_W_DFLT - 1;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way picker. Tie-break is round-robin when DMEM_ARB_RR_EN is
// defined, otherwise fixed priority to m0.
module dmem_arb_pick (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       rr_last_i,
  input  logic [1:0] excl_i,
  output logic       gnt0_o,
  output logic       gnt1_o
);

  logic tie_win;
  logic base_win;

`ifdef DMEM_ARB_RR_EN
  assign base_win = ~rr_last_i;
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last_i;
  assign base_win       = 1'b0;
`endif

  // A master being forced off a lock loses the tie to the other one.
  always_comb begin
    tie_win = base_win;
    if (excl_i[0]) tie_win = 1'b1;
    if (excl_i[1]) tie_win = 1'b0;
  end

  assign gnt0_o = req0_i & (~req1_i | ~tie_win);
  assign gnt1_o = req1_i & (~req0_i |  tie_win);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the DMEM data port with lock support and 1-cycle read return.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default build is fixed priority (m0 wins).
module dmem_arbiter
  import strontium_dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_ask_addr,
  output logic [ADDR_W-1:0] dmem_fetch_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata
);

  localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              rr_last_q, rr_last_d;
  rd_tag_t           rd_tag_q, rd_tag_d;
  logic [ADDR_W-1:0] fetch_addr_q;

  logic       pick_en;
  logic [1:0] excl;
  logic       hold_gnt0, hold_gnt1;
  logic       pick_gnt0, pick_gnt1;

  dmem_arb_pick u_pick (
    .req0_i    (m0_req),
    .req1_i    (m1_req),
    .rr_last_i (rr_last_q),
    .excl_i    (excl),
    .gnt0_o    (pick_gnt0),
    .gnt1_o    (pick_gnt1)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = rr_last_q;
    pick_en    = 1'b0;
    excl       = 2'b00;
    hold_gnt0  = 1'b0;
    hold_gnt1  = 1'b0;

    unique case (state_q)
      IDLE: pick_en = 1'b1;
      OWN0: begin
        if (m0_lock && lock_cnt_q != CNT_MAX) begin
          hold_gnt0  = m0_req;
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end else begin
          pick_en    = 1'b1;
          state_d    = IDLE;
          lock_cnt_d = '0;
          if (m0_lock) begin
            excl = 2'b01;
`ifdef DMEM_ARB_RR_EN
            rr_last_d = M_CPU;
`endif
          end
        end
      end
      OWN1: begin
        if (m1_lock && lock_cnt_q != CNT_MAX) begin
          hold_gnt1  = m1_req;
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end else begin
          pick_en    = 1'b1;
          state_d    = IDLE;
          lock_cnt_d = '0;
          if (m1_lock) begin
            excl = 2'b10;
`ifdef DMEM_ARB_RR_EN
            rr_last_d = M_DBG;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Grants drop the moment reset asserts, not at the next edge.
    m0_gnt = ~rst & (hold_gnt0 | (pick_en & pick_gnt0));
    m1_gnt = ~rst & (hold_gnt1 | (pick_en & pick_gnt1));

    if (pick_en && (m0_gnt || m1_gnt)) begin
`ifdef DMEM_ARB_RR_EN
      rr_last_d = m1_gnt ? M_DBG : M_CPU;
`endif
      if (m0_gnt && m0_lock) begin
        state_d    = OWN0;
        lock_cnt_d = CNT_ONE;
      end else if (m1_gnt && m1_lock) begin
        state_d    = OWN1;
        lock_cnt_d = CNT_ONE;
      end
    end
  end

  always_comb begin
    dmem_we       = 1'b0;
    dmem_ask_addr = fetch_addr_q;
    dmem_wdata    = '0;
    if (m0_gnt) begin
      dmem_we       = m0_we;
      dmem_ask_addr = m0_addr;
      dmem_wdata    = m0_wdata;
    end else if (m1_gnt) begin
      dmem_we       = m1_we;
      dmem_ask_addr = m1_addr;
      dmem_wdata    = m1_wdata;
    end
  end

  assign rd_tag_d.valid  = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
  assign rd_tag_d.master = m1_gnt ? M_DBG : M_CPU;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      rr_last_q    <= 1'b1;
      rd_tag_q     <= '0;
      fetch_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      rr_last_q    <= rr_last_d;
      rd_tag_q     <= rd_tag_d;
      fetch_addr_q <= dmem_ask_addr;
    end
  end

  assign dmem_fetch_addr = fetch_addr_q;
  assign m0_rvalid = rd_tag_q.valid & (rd_tag_q.master == M_CPU);
  assign m1_rvalid = rd_tag_q.valid & (rd_tag_q.master == M_DBG);
  assign m0_rdata  = dmem_rdata;
  assign m1_rdata  = dmem_rdata;

endmodule
